// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter.
//   reg_idx_t        : architectural register index (x0..x31)
//   word_t           : 32-bit data word
//   wb_entry_t       : buffered long-latency result {rd, data}
//   WB_DEPTH_DEFAULT : default long-latency result FIFO depth
package wb_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    localparam int unsigned WB_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t holding long-latency results until a
// register-file write slot is free.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (flushes contents)
//   push, push_entry  : enqueue an entry (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   head              : current head entry (valid when !empty)
//   full, empty       : occupancy flags
//   count             : number of entries held, $clog2(DEPTH)+1 bits
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    wb_entry_t       mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Contents need no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter for the register file's single write port. The ALU
// pipeline (no stall) has priority; long-latency results are buffered in a
// FIFO and written when the ALU leaves the slot free. An optional per-register
// busy scoreboard produces the decode hazard stall.
// Build option: define WB_SCOREBOARD_EN to include the scoreboard; otherwise
// hazard_stall is tied low and issue_*/chk_* are ignored.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   alu_wb_valid/reg/data             : ALU result this cycle
//   lu_valid/reg/data, lu_ready       : long-latency result handshake
//   issue_valid, issue_reg            : long-latency op issued from decode
//   chk_reg1, chk_reg2, chk_dst       : decode registers to check
//   hazard_stall                      : a checked register is busy
//   write_reg, dst_reg, dst_data      : registered register-file write port
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     alu_wb_valid,
    input  reg_idx_t alu_wb_reg,
    input  word_t    alu_wb_data,
    input  logic     lu_valid,
    input  reg_idx_t lu_reg,
    input  word_t    lu_data,
    output logic     lu_ready,
    input  logic     issue_valid,
    input  reg_idx_t issue_reg,
    input  reg_idx_t chk_reg1,
    input  reg_idx_t chk_reg2,
    input  reg_idx_t chk_dst,
    output logic     hazard_stall,
    output logic     write_reg,
    output reg_idx_t dst_reg,
    output word_t    dst_data
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            rdy_q;
    logic            alu_claim, fifo_pop, lu_push;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    wb_entry_t       fifo_head, lu_entry;
    logic            write_d;
    reg_idx_t        dst_reg_d;
    word_t           dst_data_d;

    // Holds lu_ready low through reset and releases it one cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= 1'b1;
    end

    // Registered count only, so a pop never makes room for a same-cycle push.
    assign lu_ready  = rdy_q & (fifo_count < CntW'(DEPTH));
    assign alu_claim = alu_wb_valid & (alu_wb_reg != '0);
    assign fifo_pop  = ~alu_claim & ~fifo_empty;
    // Results to x0 are acknowledged but dropped.
    assign lu_push   = lu_valid & lu_ready & (lu_reg != '0);
    assign lu_entry  = '{rd: lu_reg, data: lu_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lu_push),
        .push_entry (lu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        write_d    = 1'b0;
        dst_reg_d  = '0;
        dst_data_d = '0;
        if (alu_claim) begin
            write_d    = 1'b1;
            dst_reg_d  = alu_wb_reg;
            dst_data_d = alu_wb_data;
        end else if (fifo_pop) begin
            write_d    = 1'b1;
            dst_reg_d  = fifo_head.rd;
            dst_data_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg <= 1'b0;
            dst_reg   <= '0;
            dst_data  <= '0;
        end else begin
            write_reg <= write_d;
            dst_reg   <= dst_reg_d;
            dst_data  <= dst_data_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Set after clear so an issue to a register being written keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && (issue_reg != '0)) begin
            busy_d[issue_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign hazard_stall = busy_q[chk_reg1] | busy_q[chk_reg2] | busy_q[chk_dst];

    logic unused_sb;
    assign unused_sb = fifo_full;
`else
    assign hazard_stall = 1'b0;

    logic unused_sb;
    assign unused_sb = ^{fifo_full, issue_valid, issue_reg, chk_reg1, chk_reg2, chk_dst};
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    import wb_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     alu_wb_valid;
    reg_idx_t alu_wb_reg;
    word_t    alu_wb_data;
    logic     lu_valid;
    reg_idx_t lu_reg;
    word_t    lu_data;
    logic     lu_ready;
    logic     issue_valid;
    reg_idx_t issue_reg;
    reg_idx_t chk_reg1, chk_reg2, chk_dst;
    logic     hazard_stall;
    logic     write_reg;
    reg_idx_t dst_reg;
    word_t    dst_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_writeback #(
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_reg   (alu_wb_reg),
        .alu_wb_data  (alu_wb_data),
        .lu_valid     (lu_valid),
        .lu_reg       (lu_reg),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .chk_reg1     (chk_reg1),
        .chk_reg2     (chk_reg2),
        .chk_dst      (chk_dst),
        .hazard_stall (hazard_stall),
        .write_reg    (write_reg),
        .dst_reg      (dst_reg),
        .dst_data     (dst_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic w, input reg_idx_t r, input word_t d);
        chk({tag, ".write_reg"}, 32'(write_reg), 32'(w));
        chk({tag, ".dst_reg"}, 32'(dst_reg), 32'(r));
        chk({tag, ".dst_data"}, dst_data, d);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stall when a busy register is checked.
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    initial begin
        rst = 1'b1;
        alu_wb_valid = 0; alu_wb_reg = '0; alu_wb_data = '0;
        lu_valid = 0; lu_reg = '0; lu_data = '0;
        issue_valid = 0; issue_reg = '0;
        chk_reg1 = '0; chk_reg2 = '0; chk_dst = '0;

        // Reset state
        #3;
        chk_wr("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.lu_ready", 32'(lu_ready), 32'd0);
        chk("reset.hazard", 32'(hazard_stall), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_reset.lu_ready", 32'(lu_ready), 32'd1);
        chk_wr("post_reset", 1'b0, 5'd0, 32'h0);

        // ALU single write, one-cycle latency
        alu_wb_valid = 1; alu_wb_reg = 5'd5; alu_wb_data = 32'hDEADBEEF;
        step();
        chk_wr("alu_r5", 1'b1, 5'd5, 32'hDEADBEEF);
        alu_wb_valid = 0;
        step();
        chk_wr("alu_idle", 1'b0, 5'd0, 32'h0);

        // ALU and LU in the same cycle: ALU first, LU next
        alu_wb_valid = 1; alu_wb_reg = 5'd3; alu_wb_data = 32'h11;
        lu_valid = 1; lu_reg = 5'd7; lu_data = 32'h22;
        step();
        chk_wr("both_alu_r3", 1'b1, 5'd3, 32'h11);
        alu_wb_valid = 0; lu_valid = 0;
        step();
        chk_wr("both_lu_r7", 1'b1, 5'd7, 32'h22);
        step();
        chk_wr("both_idle", 1'b0, 5'd0, 32'h0);

        // Scoreboard: issue r9, stall until r9 is written
        issue_valid = 1; issue_reg = 5'd9;
        step();
        issue_valid = 0; chk_reg1 = 5'd9;
        #1;
        chk("sb_r9_busy", 32'(hazard_stall), 32'(SB));
        lu_valid = 1; lu_reg = 5'd9; lu_data = 32'h99;
        step();
        chk("sb_r9_pushed_busy", 32'(hazard_stall), 32'(SB));
        chk_wr("sb_r9_pushed", 1'b0, 5'd0, 32'h0);
        lu_valid = 0;
        step();
        chk_wr("sb_r9_write", 1'b1, 5'd9, 32'h99);
        chk("sb_r9_clear", 32'(hazard_stall), 32'd0);
        chk_reg1 = '0;
        // x0 is never busy; chk_dst path
        issue_valid = 1; issue_reg = 5'd0;
        step();
        issue_valid = 0;
        #1;
        chk("sb_r0_never_busy", 32'(hazard_stall), 32'd0);
        issue_valid = 1; issue_reg = 5'd12;
        step();
        issue_valid = 0; chk_dst = 5'd12;
        #1;
        chk("sb_r12_dst_busy", 32'(hazard_stall), 32'(SB));
        lu_valid = 1; lu_reg = 5'd12; lu_data = 32'hC0;
        step();
        lu_valid = 0;
        step();
        chk_wr("sb_r12_write", 1'b1, 5'd12, 32'hC0);
        chk("sb_r12_clear", 32'(hazard_stall), 32'd0);
        chk_dst = '0;

        // Continuous ALU starves the FIFO; lu_ready drops after 2 accepts
        alu_wb_valid = 1; alu_wb_reg = 5'd1; alu_wb_data = 32'hA1;
        lu_valid = 1; lu_reg = 5'd10; lu_data = 32'hA0;
        step();
        chk("fill1.lu_ready", 32'(lu_ready), 32'd1);
        chk_wr("fill1", 1'b1, 5'd1, 32'hA1);
        lu_reg = 5'd11; lu_data = 32'hB0;
        step();
        chk("fill2.lu_ready", 32'(lu_ready), 32'd0);
        lu_reg = 5'd12; lu_data = 32'hC1;
        step();
        chk("full_hold.lu_ready", 32'(lu_ready), 32'd0);
        chk_wr("full_hold", 1'b1, 5'd1, 32'hA1);
        alu_wb_valid = 0;
        step();
        chk_wr("drain_r10", 1'b1, 5'd10, 32'hA0);
        chk("drain_r10.lu_ready", 32'(lu_ready), 32'd1);
        step();
        chk_wr("drain_r11", 1'b1, 5'd11, 32'hB0);
        lu_valid = 0;
        step();
        chk_wr("drain_r12", 1'b1, 5'd12, 32'hC1);
        step();
        chk_wr("drain_idle", 1'b0, 5'd0, 32'h0);

        // ALU write to x0 leaves the slot for the FIFO
        alu_wb_valid = 1; alu_wb_reg = 5'd1; alu_wb_data = 32'h1;
        lu_valid = 1; lu_reg = 5'd4; lu_data = 32'h44;
        step();
        lu_valid = 0; alu_wb_reg = 5'd0; alu_wb_data = 32'h55;
        step();
        chk_wr("alu_x0_fifo_r4", 1'b1, 5'd4, 32'h44);
        // LU result to x0: accepted, never written
        alu_wb_valid = 0;
        lu_valid = 1; lu_reg = 5'd0; lu_data = 32'h66;
        #1;
        chk("lu_x0.lu_ready", 32'(lu_ready), 32'd1);
        step();
        chk_wr("lu_x0_a", 1'b0, 5'd0, 32'h0);
        lu_valid = 0;
        step();
        chk_wr("lu_x0_b", 1'b0, 5'd0, 32'h0);

        // Reset mid-operation with two buffered entries and busy[4]
        alu_wb_valid = 1; alu_wb_reg = 5'd1; alu_wb_data = 32'h77;
        issue_valid = 1; issue_reg = 5'd4;
        lu_valid = 1; lu_reg = 5'd4; lu_data = 32'h40;
        step();
        issue_valid = 0; lu_reg = 5'd5; lu_data = 32'h50;
        step();
        lu_valid = 0; chk_reg1 = 5'd4;
        #1;
        chk("rst_pre.hazard", 32'(hazard_stall), 32'(SB));
        chk("rst_pre.lu_ready", 32'(lu_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_wr("rst_mid", 1'b0, 5'd0, 32'h0);
        chk("rst_mid.lu_ready", 32'(lu_ready), 32'd0);
        chk("rst_mid.hazard", 32'(hazard_stall), 32'd0);
        alu_wb_valid = 0;
        step();
        rst = 1'b0;
        step();
        chk("rst_after.lu_ready", 32'(lu_ready), 32'd1);
        chk_wr("rst_after_a", 1'b0, 5'd0, 32'h0);
        chk("rst_after.hazard", 32'(hazard_stall), 32'd0);
        step();
        chk_wr("rst_after_b", 1'b0, 5'd0, 32'h0);
        step();
        chk_wr("rst_after_c", 1'b0, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
